// File: rtl/tile_pixel_fetch.sv
// Per-scanline tile fetcher: walks one tile row, reads tilemap then pattern ROM,
// and streams eight 4-bit {pal, pixel} color indices per tile over valid/ready.
module tile_pixel_fetch #(
  parameter int TILES_PER_ROW = 28,
  parameter int TILE_ROWS     = 36
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [8:0]  line_y,
  output logic [9:0]  map_addr,
  input  logic [9:0]  map_data,
  output logic [10:0] rom_addr,
  input  logic [15:0] rom_data,
  output logic [3:0]  color_index,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        busy,
  output logic        line_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MAP,
    S_CODE,
    S_ROW,
    S_LOAD,
    S_SHIFT,
    S_DONE
  } state_e;

  localparam logic [9:0] NUM_LINES = 10'(8 * TILE_ROWS);
  localparam logic [4:0] LAST_COL  = 5'(TILES_PER_ROW - 1);

  state_e      state_q, state_d;
  logic [5:0]  tile_row_q;
  logic [2:0]  fine_y_q;
  logic [4:0]  col_q;
  logic [7:0]  code_q;
  logic [1:0]  pal_q;
  logic [15:0] sh_q;
  logic [2:0]  pixcnt_q;

  logic accept;
  logic handshake;
  logic tile_end;

  assign accept    = (state_q == S_IDLE) && line_start && ({1'b0, line_y} < NUM_LINES);
  assign handshake = (state_q == S_SHIFT) && pix_ready;
  assign tile_end  = handshake && (pixcnt_q == 3'd7);

  // Addresses are derived purely from registered fields
  assign map_addr = 10'(tile_row_q) * 10'(TILES_PER_ROW) + 10'(col_q);
  assign rom_addr = {code_q, fine_y_q};

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_MAP;
      S_MAP:   state_d = S_CODE;
      S_CODE:  state_d = S_ROW;
      S_ROW:   state_d = S_LOAD;
      S_LOAD:  state_d = S_SHIFT;
      S_SHIFT: if (tile_end) state_d = (col_q == LAST_COL) ? S_DONE : S_MAP;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state; color index forced to zero when not valid
  always_comb begin
    pix_valid   = (state_q == S_SHIFT);
    busy        = (state_q != S_IDLE);
    line_done   = (state_q == S_DONE);
    color_index = (state_q == S_SHIFT) ? {pal_q, sh_q[1:0]} : '0;
  end

  // Datapath: line fields, tile attributes, pixel shifter and counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tile_row_q <= '0;
      fine_y_q   <= '0;
      col_q      <= '0;
      code_q     <= '0;
      pal_q      <= '0;
      sh_q       <= '0;
      pixcnt_q   <= '0;
    end else begin
      if (accept) begin
        tile_row_q <= line_y[8:3];
        fine_y_q   <= line_y[2:0];
        col_q      <= '0;
      end
      if (state_q == S_CODE) begin
        code_q <= map_data[7:0];
        pal_q  <= map_data[9:8];
      end
      if (state_q == S_LOAD) begin
        sh_q     <= rom_data;
        pixcnt_q <= '0;
      end
      if (handshake) begin
        sh_q     <= sh_q >> 2;
        pixcnt_q <= pixcnt_q + 3'd1;
      end
      if (tile_end && (col_q != LAST_COL)) col_q <= col_q + 5'd1;
    end
  end

endmodule

// File: tb/tb_tile_pixel_fetch.sv
// Directed bench for tile_pixel_fetch with registered tilemap/ROM models.
module tb_tile_pixel_fetch;

  logic        clk;
  logic        rst;
  logic        line_start;
  logic [8:0]  line_y;
  logic [9:0]  map_addr;
  logic [9:0]  map_data;
  logic [10:0] rom_addr;
  logic [15:0] rom_data;
  logic [3:0]  color_index;
  logic        pix_valid;
  logic        pix_ready;
  logic        busy;
  logic        line_done;

  logic [9:0]  map_mem [1024];
  logic [15:0] rom_mem [2048];

  int n_assert = 0;
  int n_fail   = 0;

  tile_pixel_fetch #(.TILES_PER_ROW(28), .TILE_ROWS(36)) dut (
    .clk(clk), .rst(rst), .line_start(line_start), .line_y(line_y),
    .map_addr(map_addr), .map_data(map_data), .rom_addr(rom_addr), .rom_data(rom_data),
    .color_index(color_index), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .busy(busy), .line_done(line_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle read latency memories
  always @(posedge clk) begin
    map_data <= map_mem[map_addr];
    rom_data <= rom_mem[rom_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_pix(input logic [5:0] row, input logic [2:0] fy,
                                         input int col, input int k);
    logic [9:0]  m;
    logic [15:0] d;
    m = map_mem[10'(int'(row) * 28 + col)];
    d = rom_mem[{m[7:0], fy}];
    d = d >> (2 * k);
    return {m[9:8], d[1:0]};
  endfunction

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy === 1'b1 && c < 2000) begin
      @(negedge clk);
      c++;
    end
    check(tag, busy, 0);
  endtask

  // Runs one line, checking every pixel against the model; bp selects ready pattern 1,0,0
  task automatic fetch_line(input logic [8:0] y, input int bp, input int inj_cyc,
                            input logic [8:0] inj_y, output int npix, output int ndone,
                            output int ncol);
    int col, k, cyc;
    bit finished;
    logic [5:0] row;
    logic [2:0] fy;
    row = y[8:3];
    fy  = y[2:0];
    col = 0; k = 0; npix = 0; ndone = 0; finished = 0; cyc = 0;
    @(negedge clk);
    line_y = y;
    line_start = 1'b1;
    pix_ready = 1'b1;
    while (!finished && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      line_start = (cyc == inj_cyc);
      if (cyc == inj_cyc) line_y = inj_y;
      pix_ready = (bp == 0) ? 1'b1 : ((cyc % 3) == 0);
      if (line_done === 1'b1) begin
        ndone++;
        finished = 1;
      end
      if (pix_valid === 1'b1) begin
        check("pixel", color_index, exp_pix(row, fy, col, k));
        if (k == 0) begin
          check("map_addr_seq", map_addr, int'(row) * 28 + col);
          check("rom_fine_y", rom_addr[2:0], fy);
        end
        if (pix_ready) begin
          npix++;
          k++;
          if (k == 8) begin
            k = 0;
            col++;
          end
        end
      end else begin
        check("ci_zero_idle", color_index, 0);
      end
    end
    check("line_timeout", finished, 1);
    ncol = col;
    @(negedge clk);
    line_start = 1'b0;
    pix_ready = 1'b1;
    check("busy_after_line", busy, 0);
    check("done_single", line_done, 0);
  endtask

  initial begin
    int npix, ndone, ncol, c;
    logic [3:0] basic_exp [8];
    basic_exp = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h8, 4'h9, 4'hA, 4'hB};

    for (int i = 0; i < 1024; i++) map_mem[i] = 10'((i * 37 + 11) ^ (i >> 2));
    for (int i = 0; i < 2048; i++) rom_mem[i] = 16'(i * 40503 + 12345);
    map_mem[0]     = 10'h2A5;
    rom_mem[11'h528] = 16'hE4E4;

    rst = 1'b0; line_start = 1'b0; line_y = '0; pix_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_line_done", line_done, 0);
    check("rst_color", color_index, 0);
    check("rst_map_addr", map_addr, 0);
    check("rst_rom_addr", rom_addr, 0);
    rst = 1'b1;
    @(negedge clk);
    check("idle_busy", busy, 0);

    // Basic tile with latency checks
    pix_ready = 1'b1;
    line_y = 9'd0;
    line_start = 1'b1;                       // T0
    @(negedge clk);                          // T1
    line_start = 1'b0;
    check("basic_T1_map_addr", map_addr, 0);
    check("basic_T1_busy", busy, 1);
    check("basic_T1_valid", pix_valid, 0);
    @(negedge clk);                          // T2
    check("basic_T2_valid", pix_valid, 0);
    @(negedge clk);                          // T3
    check("basic_T3_rom_addr", rom_addr, 11'h528);
    @(negedge clk);                          // T4
    check("basic_T4_valid", pix_valid, 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);                        // T5..T12
      check("basic_valid", pix_valid, 1);
      check("basic_color", color_index, basic_exp[i]);
    end
    wait_idle("basic_idle");

    // Full last line of the frame
    fetch_line(9'd287, 0, -1, 9'd0, npix, ndone, ncol);
    check("full_pix_count", npix, 224);
    check("full_done_count", ndone, 1);
    check("full_col_count", ncol, 28);

    // Backpressure
    fetch_line(9'd100, 1, -1, 9'd0, npix, ndone, ncol);
    check("bp_pix_count", npix, 224);
    check("bp_done_count", ndone, 1);

    // Out-of-range line is ignored
    @(negedge clk);
    line_y = 9'd300;
    line_start = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      line_start = 1'b0;
      check("oor_busy", busy, 0);
      check("oor_done", line_done, 0);
    end

    // Second request mid-line does not restart
    fetch_line(9'd50, 0, 30, 9'd200, npix, ndone, ncol);
    check("mid_pix_count", npix, 224);
    check("mid_done_count", ndone, 1);
    check("mid_col_count", ncol, 28);

    // Reset during tile 5
    @(negedge clk);
    line_y = 9'd16;
    line_start = 1'b1;
    for (int i = 1; i <= 67; i++) begin
      @(negedge clk);
      line_start = 1'b0;
    end
    check("rstmid_pre_valid", pix_valid, 1);
    check("rstmid_pre_map", map_addr, 2 * 28 + 5);
    rst = 1'b0;
    #1;
    check("rstmid_valid", pix_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_color", color_index, 0);
    check("rstmid_map", map_addr, 0);
    check("rstmid_rom", rom_addr, 0);
    @(negedge clk);
    check("rstmid_no_done", line_done, 0);
    rst = 1'b1;
    @(negedge clk);
    line_y = 9'd8;
    line_start = 1'b1;                       // T0
    @(negedge clk);                          // T1
    line_start = 1'b0;
    check("rstnew_T1_map", map_addr, 28);
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      check("rstnew_early_valid", pix_valid, 0);
    end
    @(negedge clk);                          // T5
    check("rstnew_T5_valid", pix_valid, 1);
    check("rstnew_T5_color", color_index, exp_pix(6'd1, 3'd0, 0, 0));
    wait_idle("rstnew_idle");

    // Back-to-back: pulse in the done cycle is ignored, next cycle accepted
    @(negedge clk);
    line_y = 9'd8;
    line_start = 1'b1;
    @(negedge clk);
    line_start = 1'b0;
    c = 0;
    while (line_done !== 1'b1 && c < 1000) begin
      @(negedge clk);
      c++;
    end
    check("b2b_done_seen", line_done, 1);
    check("b2b_busy_in_done", busy, 1);
    line_y = 9'd40;
    line_start = 1'b1;
    @(negedge clk);
    check("b2b_idle_gap", busy, 0);
    line_y = 9'd64;                          // T0 of the accepted line
    @(negedge clk);                          // T1
    line_start = 1'b0;
    check("b2b_T1_map", map_addr, 8 * 28);
    check("b2b_T1_busy", busy, 1);
    repeat (4) @(negedge clk);               // T5
    check("b2b_T5_valid", pix_valid, 1);
    check("b2b_T5_color", color_index, exp_pix(6'd8, 3'd0, 0, 0));
    wait_idle("b2b_idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
